data_ram: RTL and testbench

- Data-memory responder: the far end of the CPU's MEM-stage RAM port (operation, byte select, address, write data, chip enable).
- Serves word reads combinationally and byte-masked writes on the clock edge, so the MEM stage finishes in one cycle.
- After reset, a clear sequencer zeroes the whole array and raises a stall request. The top level ORs this into the control unit's stall sources.

---
 rtl/data_ram_pkg.sv | 21 ++
 rtl/data_ram_clear_sequencer.sv | 43 ++++
 rtl/data_ram.sv | 65 ++++++
 tb/tb_data_ram.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_ram_pkg.sv
// Shared bus widths, RAM operation codes and clear-sequencer state encoding
// for the data-memory responder.
package data_ram_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_DATA_W = 32;
  localparam int unsigned BYTE_SEL_W  = 4;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [INST_DATA_W-1:0] inst_data_t;
  typedef logic [BYTE_SEL_W-1:0]  byte_sel_t;

  localparam logic RAM_OP_READ  = 1'b0;
  localparam logic RAM_OP_WRITE = 1'b1;

  typedef enum logic {
    RAM_STATE_CLEAR = 1'b0,
    RAM_STATE_READY = 1'b1
  } ram_state_e;

endpackage

// File: rtl/data_ram_clear_sequencer.sv
// Post-reset clear sequencer: walks every word address once, driving a zero
// write port, and holds a stall request until the last word is cleared.
module ram_clear_sequencer
  import data_ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter bit          INIT_CLEAR = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic                  stall_o,
  output logic                  clr_we_o,
  output logic [ADDR_WIDTH-1:0] clr_addr_o
);

  ram_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= INIT_CLEAR ? RAM_STATE_CLEAR : RAM_STATE_READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall_o    = 1'b0;
    clr_we_o   = 1'b0;
    clr_addr_o = cnt_q;
    if (state_q == RAM_STATE_CLEAR) begin
      stall_o  = 1'b1;
      clr_we_o = 1'b1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == '1) state_d = RAM_STATE_READY;
    end
  end

endmodule

// File: rtl/data_ram.sv
// Data-memory responder for the MEM stage: combinational word reads,
// byte-masked clocked writes, and a post-reset array clear with stall.
module data_ram
  import data_ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter bit          INIT_CLEAR = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             chip_enable,
  input  logic             operation,
  input  byte_sel_t        select_signal,
  input  inst_addr_t       addr,
  input  inst_data_t       write_data,
  output inst_data_t       read_data,
  output logic             stall_request,
  output logic             out_of_range
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  inst_data_t            mem [DEPTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic                  in_range;
  logic                  ready;
  logic                  rd_en;
  logic                  wr_en;
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [1:0]            unused_byte_offset;

  ram_clear_sequencer #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_CLEAR (INIT_CLEAR)
  ) u_clear_seq (
    .clk_i      (clock),
    .rst_ni     (reset),
    .stall_o    (stall_request),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  assign unused_byte_offset = addr[1:0];
  assign idx                = addr[ADDR_WIDTH+1:2];
  assign in_range           = ((addr >> (ADDR_WIDTH + 2)) == '0);

  // Reset is folded in so nothing leaks out while the state register is held.
  assign ready        = reset & ~stall_request;
  assign rd_en        = ready & chip_enable & in_range & (operation == RAM_OP_READ);
  assign wr_en        = ready & chip_enable & in_range & (operation == RAM_OP_WRITE);
  assign read_data    = rd_en ? mem[idx] : '0;
  assign out_of_range = ready & chip_enable & ~in_range;

  always_ff @(posedge clock) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < BYTE_SEL_W; i++) begin
        if (select_signal[i]) mem[idx][8*i +: 8] <= write_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_ram.sv
// Scoreboard bench for data_ram: one instance with INIT_CLEAR=1, one with
// INIT_CLEAR=0, both ADDR_WIDTH=4 (16 words), sharing clock and access inputs.
module tb_data_ram;

  logic        clock = 1'b0;
  logic        rst1, rst0;
  logic        chip_enable, operation;
  logic [3:0]  sel;
  logic [31:0] addr, wdata;
  logic [31:0] rd1, rd0;
  logic        stall1, stall0, oor1, oor0;

  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] sb_q [$];

  always #5 clock = ~clock;

  data_ram #(.ADDR_WIDTH(4), .INIT_CLEAR(1'b1)) dut (
    .clock(clock), .reset(rst1), .chip_enable(chip_enable), .operation(operation),
    .select_signal(sel), .addr(addr), .write_data(wdata),
    .read_data(rd1), .stall_request(stall1), .out_of_range(oor1)
  );

  data_ram #(.ADDR_WIDTH(4), .INIT_CLEAR(1'b0)) dut0 (
    .clock(clock), .reset(rst0), .chip_enable(chip_enable), .operation(operation),
    .select_signal(sel), .addr(addr), .write_data(wdata),
    .read_data(rd0), .stall_request(stall0), .out_of_range(oor0)
  );

  // Apply one access in the low clock phase and queue the expected read_data.
  task automatic drive(input logic en, input logic op, input logic [3:0] s,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp);
    @(negedge clock);
    chip_enable = en; operation = op; sel = s; addr = a; wdata = wd;
    sb_q.push_back(exp);
    #1;
  endtask

  task automatic count_clear(input string name);
    int cnt;
    bit done;
    cnt = 0; done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clock); #1;
      cnt++;
      if (cnt == 8) begin
        vectors++;
        if (rd1 !== 32'h0) begin
          miscompares++; $display("FAIL %s_read_during_clear: got %h expected 00000000", name, rd1);
        end
      end
      if (!stall1) done = 1;
    end
    vectors++;
    if (!done || cnt != 16) begin
      miscompares++; $display("FAIL %s_stall_cycles: got %0d (done=%0d) expected 16", name, cnt, done);
    end
  endtask

  task automatic test_reset;
    logic [31:0] exp;
    rst1 = 1'b0; rst0 = 1'b0;
    drive(1'b1, 1'b0, 4'hF, 32'h8, 32'h0, 32'h0);
    @(negedge clock); #1;
    exp = sb_q.pop_front();
    vectors++;
    if (rd1 !== exp) begin miscompares++; $display("FAIL reset_read_data: got %h expected %h", rd1, exp); end
    vectors++;
    if (stall1 !== 1'b1) begin miscompares++; $display("FAIL reset_stall: got %b expected 1", stall1); end
    vectors++;
    if (oor1 !== 1'b0) begin miscompares++; $display("FAIL reset_oor: got %b expected 0", oor1); end
    vectors++;
    if (stall0 !== 1'b0) begin miscompares++; $display("FAIL reset_stall_noclear: got %b expected 0", stall0); end
    @(negedge clock);
    addr = 32'h3C;
    rst1 = 1'b1;
    #1;
    vectors++;
    if (stall1 !== 1'b1) begin miscompares++; $display("FAIL release_stall: got %b expected 1", stall1); end
    count_clear("initial");
    drive(1'b1, 1'b0, 4'hF, 32'h3C, 32'h0, 32'h0);
    exp = sb_q.pop_front();
    vectors++;
    if (rd1 !== exp) begin miscompares++; $display("FAIL read_0x3C_after_clear: got %h expected %h", rd1, exp); end
  endtask

  task automatic test_full_write;
    logic [31:0] exp;
    drive(1'b1, 1'b1, 4'hF, 32'h8, 32'hDEADBEEF, 32'h0);
    exp = sb_q.pop_front();
    vectors++;
    if (rd1 !== exp) begin miscompares++; $display("FAIL write_read_data: got %h expected %h", rd1, exp); end
    drive(1'b1, 1'b0, 4'hF, 32'h8, 32'h0, 32'hDEADBEEF);
    exp = sb_q.pop_front();
    vectors++;
    if (rd1 !== exp) begin miscompares++; $display("FAIL read_0x8_full: got %h expected %h", rd1, exp); end
  endtask

  task automatic test_byte_lanes;
    logic [31:0] exp;
    drive(1'b1, 1'b1, 4'b0100, 32'h8, 32'h00AA0000, 32'h0);
    void'(sb_q.pop_front());
    drive(1'b1, 1'b0, 4'b0000, 32'h8, 32'h0, 32'hDEAABEEF);
    exp = sb_q.pop_front();
    vectors++;
    if (rd1 !== exp) begin miscompares++; $display("FAIL read_0x8_lane2: got %h expected %h", rd1, exp); end
    drive(1'b1, 1'b1, 4'b0000, 32'h8, 32'h11111111, 32'h0);
    void'(sb_q.pop_front());
    drive(1'b1, 1'b0, 4'hF, 32'h8, 32'h0, 32'hDEAABEEF);
    exp = sb_q.pop_front();
    vectors++;
    if (rd1 !== exp) begin miscompares++; $display("FAIL read_0x8_sel0: got %h expected %h", rd1, exp); end
    drive(1'b1, 1'b1, 4'b1001, 32'h8, 32'h55667788, 32'h0);
    void'(sb_q.pop_front());
    drive(1'b1, 1'b0, 4'hF, 32'h8, 32'h0, 32'h55AABE88);
    exp = sb_q.pop_front();
    vectors++;
    if (rd1 !== exp) begin miscompares++; $display("FAIL read_0x8_lanes30: got %h expected %h", rd1, exp); end
  endtask

  task automatic test_out_of_range;
    logic [31:0] exp;
    drive(1'b1, 1'b1, 4'hF, 32'h0, 32'h11223344, 32'h0);
    void'(sb_q.pop_front());
    drive(1'b1, 1'b1, 4'hF, 32'h3C, 32'hA5A5A5A5, 32'h0);
    void'(sb_q.pop_front());
    vectors++;
    if (oor1 !== 1'b0) begin miscompares++; $display("FAIL oor_last_word: got %b expected 0", oor1); end
    drive(1'b1, 1'b1, 4'hF, 32'h40, 32'hFFFFFFFF, 32'h0);
    void'(sb_q.pop_front());
    vectors++;
    if (oor1 !== 1'b1) begin miscompares++; $display("FAIL oor_write_0x40: got %b expected 1", oor1); end
    drive(1'b1, 1'b0, 4'hF, 32'h0, 32'h0, 32'h11223344);
    exp = sb_q.pop_front();
    vectors++;
    if (rd1 !== exp) begin miscompares++; $display("FAIL read_0x0_unaffected: got %h expected %h", rd1, exp); end
    drive(1'b1, 1'b0, 4'hF, 32'h3C, 32'h0, 32'hA5A5A5A5);
    exp = sb_q.pop_front();
    vectors++;
    if (rd1 !== exp) begin miscompares++; $display("FAIL read_0x3C: got %h expected %h", rd1, exp); end
    drive(1'b1, 1'b0, 4'hF, 32'h40, 32'h0, 32'h0);
    exp = sb_q.pop_front();
    vectors++;
    if (rd1 !== exp) begin miscompares++; $display("FAIL read_0x40: got %h expected %h", rd1, exp); end
    vectors++;
    if (oor1 !== 1'b1) begin miscompares++; $display("FAIL oor_read_0x40: got %b expected 1", oor1); end
    drive(1'b0, 1'b0, 4'hF, 32'h8, 32'h0, 32'h0);
    exp = sb_q.pop_front();
    vectors++;
    if (rd1 !== exp) begin miscompares++; $display("FAIL read_ce_low: got %h expected %h", rd1, exp); end
  endtask

  task automatic test_reset_mid_clear;
    logic [31:0] exp;
    drive(1'b1, 1'b1, 4'hF, 32'h4, 32'h12345678, 32'h0);
    void'(sb_q.pop_front());
    drive(1'b1, 1'b0, 4'hF, 32'h4, 32'h0, 32'h12345678);
    exp = sb_q.pop_front();
    vectors++;
    if (rd1 !== exp) begin miscompares++; $display("FAIL read_0x4_before_reset: got %h expected %h", rd1, exp); end
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
    void'(sb_q.pop_front());
    rst1 = 1'b0;
    @(negedge clock);
    rst1 = 1'b1;
    repeat (7) @(posedge clock);
    @(negedge clock);
    rst1 = 1'b0;
    #1;
    vectors++;
    if (stall1 !== 1'b1) begin miscompares++; $display("FAIL mid_clear_reset_stall: got %b expected 1", stall1); end
    @(negedge clock);
    rst1 = 1'b1;
    count_clear("restart");
    drive(1'b1, 1'b0, 4'hF, 32'h4, 32'h0, 32'h0);
    exp = sb_q.pop_front();
    vectors++;
    if (rd1 !== exp) begin miscompares++; $display("FAIL read_0x4_after_clear: got %h expected %h", rd1, exp); end
  endtask

  task automatic test_no_init_clear;
    logic [31:0] exp;
    drive(1'b1, 1'b1, 4'hF, 32'h4, 32'hBADBAD00, 32'h0);
    void'(sb_q.pop_front());
    @(negedge clock);
    rst0 = 1'b1;
    #1;
    vectors++;
    if (stall0 !== 1'b0) begin miscompares++; $display("FAIL noclear_stall_after_release: got %b expected 0", stall0); end
    drive(1'b1, 1'b1, 4'hF, 32'h4, 32'hCAFEF00D, 32'h0);
    exp = sb_q.pop_front();
    vectors++;
    if (rd0 !== exp) begin miscompares++; $display("FAIL noclear_write_read_data: got %h expected %h", rd0, exp); end
    drive(1'b1, 1'b0, 4'hF, 32'h4, 32'h0, 32'hCAFEF00D);
    exp = sb_q.pop_front();
    vectors++;
    if (rd0 !== exp) begin miscompares++; $display("FAIL noclear_read_0x4: got %h expected %h", rd0, exp); end
  endtask

  initial begin
    chip_enable = 1'b0; operation = 1'b0; sel = 4'h0; addr = '0; wdata = '0;
    rst1 = 1'b0; rst0 = 1'b0;
    test_reset();
    test_full_write();
    test_byte_lanes();
    test_out_of_range();
    test_reset_mid_clear();
    test_no_init_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
